// File: rtl/load_store_unit.sv
// Memory-access stage: single-outstanding load/store engine for a word-organised data memory.
// Sub-word stores are read-modify-write because the memory only has a full-word write enable.
module load_store_unit #(
  parameter int MEM_WORDS = 8,
  parameter int IDX_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_wb_en,
  output logic        resp_err,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam int          AW         = IDX_W + 2;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic [4:0]    resp_rd_q, resp_rd_d;
  logic          resp_wb_en_q, resp_wb_en_d;
  logic          resp_err_q, resp_err_d;

  logic          illegal, misaligned, out_of_range;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;
  logic [31:0]   merged;

  always_comb begin
    illegal      = req_is_store ? (req_funct3 >= 3'd3)
                                : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    misaligned   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr >= ADDR_LIMIT);
  end

  always_comb begin
    byte_sel = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_ext = {24'd0, byte_sel};
      3'd5:    load_ext = {16'd0, half_sel};
      default: load_ext = mem_read_data;
    endcase
  end

  // wdata_q doubles as the merge register: store data on accept, merged word after RMW_RD.
  always_comb begin
    merged = mem_read_data;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_wb_en_d = resp_wb_en_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr[AW-1:0];
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          if (illegal || misaligned || out_of_range) begin
            resp_data_d  = '0;
            resp_rd_d    = req_rd;
            resp_wb_en_d = 1'b0;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end else if (!req_is_store) begin
            state_d = LOAD;
          end else if (req_funct3 == 3'd2) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        resp_data_d  = load_ext;
        resp_rd_d    = rd_q;
        resp_wb_en_d = 1'b1;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      RMW_RD: begin
        wdata_d = merged;
        state_d = WRITE;
      end
      WRITE: begin
        resp_data_d  = '0;
        resp_rd_d    = rd_q;
        resp_wb_en_d = 1'b0;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_wb_en_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_wb_en_q <= resp_wb_en_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    req_ready       = (state_q == IDLE);
    resp_valid      = (state_q == RESP);
    resp_data       = resp_data_q;
    resp_rd         = resp_rd_q;
    resp_wb_en      = resp_wb_en_q;
    resp_err        = resp_err_q;
    mem_access_addr = 32'(addr_q[AW-1:2]);
    mem_write_data  = wdata_q;
    mem_read        = rst_n && (state_q == LOAD || state_q == RMW_RD);
    mem_write_en    = rst_n && (state_q == WRITE);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between execute and the word-organised data memory.
- Accepts one load or store request at a time and converts the byte address to a word index.
- Extracts and sign- or zero-extends LB/LH/LW/LBU/LHU results for writeback.
- Implements SB/SH as read-modify-write, because data memory has only a full-word write enable.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
- MEM_WORDS, 8, number of 32-bit words in data memory; byte addresses >= 4*MEM_WORDS fault.
- IDX_W, 5, width of the word index driven on mem_access_addr[IDX_W-1:0].

Ports:
- clk  in  1  clock; every register updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; request accepted when req_valid & req_ready at a rising edge.
- req_is_store  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- req_rd  in  5  destination register tag.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_data  out  32  extended load data; 0 for stores and faults.
- resp_rd  out  5  echoed req_rd.
- resp_wb_en  out  1  1 only for a successful load.
- resp_err  out  1  fault flag.
- mem_access_addr  out  32  {zeros, word index = addr[IDX_W+1:2]}.
- mem_write_data  out  32  merged store word.
- mem_write_en  out  1  word write strobe; memory writes on the rising edge.
- mem_read  out  1  read enable.
- mem_read_data  in  32  combinational read data, 0 when mem_read=0.

Behaviour:
- State machine: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE;
  - all captured registers = 0;
  - resp_* = 0;
  - mem_access_addr = 0, mem_write_data = 0.
- req_ready = (state==IDLE), so req_ready=1 after reset.
- IDLE, on accept: capture addr, funct3, wdata, rd and is_store. Fault check, in priority order:
  - Illegal funct3: load 3/6/7, store >=3.
  - Misaligned: H requires addr[0]=0; W requires addr[1:0]=0.
  - Out of range: addr >= 4*MEM_WORDS.
- Next state from IDLE:
  - Any fault -> RESP with err=1.
  - Else load -> LOAD.
  - Else SW -> WRITE.
  - Else SB/SH -> RMW_RD.
- LOAD: mem_read=1. Extract at byte lane addr[1:0] (half lane addr[1]) from mem_read_data into resp_data register, then -> RESP.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RMW_RD: mem_read=1. Merge register = mem_read_data with the addressed byte (SB, req_wdata[7:0]) or half (SH, req_wdata[15:0]) replaced; other lanes unchanged. Then -> WRITE.
- WRITE: mem_write_en=1 with mem_write_data=merge register (SW: req_wdata unchanged), then -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. resp_* registers hold until the next response.
- mem_read and mem_write_en are decoded from state and both gated by rst_n. Reset asserted during WRITE suppresses the write. Reset during any state aborts with no response.
- mem_access_addr is driven from the captured address from the cycle after accept until the next accept.
- Latency, counting the accept edge as cycle 0:
  - load: resp_valid in cycle 2;
  - SW: write in cycle 1, resp in cycle 2;
  - SB/SH: read in cycle 1, write in cycle 2, resp in cycle 3;
  - fault: resp in cycle 1.
- Requests arriving while busy are held off by req_ready=0. The requester must keep req_valid and its payload stable until accepted.
- Only one of mem_read / mem_write_en is ever high at a time. Neither is high in IDLE or RESP.

Test Plan:
1. Reset, preload word1=0x00000002, LW addr 0x4 rd=7 -> cycle1 mem_read=1, mem_access_addr=1; cycle2 resp_valid=1, resp_data=0x00000002, resp_rd=7, resp_wb_en=1, resp_err=0.
2. Word2=0x8081F0FF: LB 0x8 -> 0xFFFFFFFF; LBU 0x9 -> 0x000000F0; LH 0xA -> 0xFFFF8081; LHU 0xA -> 0x00008081.
3. Word3=0xAABBCCDD, SB 0x0D data 0x12345678 -> cycle1 mem_read=1; cycle2 mem_write_en=1, mem_write_data=0xAABB78DD; cycle3 resp_valid, resp_wb_en=0. Then SH 0x0E data 0x0000BEEF -> write 0xBEEF78DD.
4. Faults -> cycle1 resp_valid=1, resp_err=1, resp_data=0, with no mem_read or mem_write_en in any cycle: LW 0x6; SH 0x3; LW 0x20 with MEM_WORDS=8; load funct3=3.
5. Back-to-back requests: req_valid held high with SW 0x10 data 0xDEADBEEF, then LW 0x10 -> second accept only when req_ready=1 (cycle 3); load returns 0xDEADBEEF.
6. rst_n=0 during the WRITE cycle of an SB -> mem_write_en=0 that cycle, memory word unchanged, resp_valid never asserted, req_ready=1 after reset release.
